// File: rtl/div_seq_if.sv
// Request/result bundle between the control unit and the sequential divider.
// The master drives the operands and start, and the slave returns hi/lo and the status pulses.
interface div_seq_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;
   logic             done;
   logic             div_zero;

   modport master (
      output start, dividend, divisor,
      input  hi, lo, busy, done, div_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output hi, lo, busy, done, div_zero
   );
endinterface

// File: rtl/div_seq.sv
// Multicycle signed divider with MIPS DIV semantics. It produces one restoring quotient bit per clock.
// The quotient goes to lo and the remainder to hi. Both are held until the next successful divide.
module div_seq #(
   parameter int WIDTH = 32
) (
   input logic       clk,
   input logic       reset,
   div_seq_if.slave  bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      st_idle = 2'd0,
      st_run  = 2'd1,
      st_done = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_s;
   logic [CW-1:0]    cnt_r;
   logic [WIDTH-1:0] rem_r;
   logic [WIDTH-1:0] quo_r;
   logic [WIDTH-1:0] dvsr_r;
   logic [WIDTH-1:0] hi_r;
   logic [WIDTH-1:0] lo_r;
   logic             sign_q_r;
   logic             sign_rem_r;
   logic             dz_r;
   logic             busy_r;
   logic             done_r;
   logic             div_zero_r;
   logic             accept_s;
   logic             zero_s;
   logic [WIDTH-1:0] rem_sh_s;
   logic [WIDTH:0]   trial_s;

   // Two's complement negation, wrapping at WIDTH bits.
   function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] x);
      f_neg = ~x + {{(WIDTH-1){1'b0}}, 1'b1};
   endfunction

   // Magnitude as an unsigned value. The most negative input maps to 2^(WIDTH-1).
   function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] x);
      f_abs = x[WIDTH-1] ? f_neg(x) : x;
   endfunction

   // Next-state logic. A start is only accepted in idle, and a zero divisor skips run entirely.
   always_comb begin
      state_s  = state_r;
      accept_s = 1'b0;
      zero_s   = (bus.divisor == {WIDTH{1'b0}});
      case (state_r)
         st_idle: begin
            if (bus.start) begin
               accept_s = 1'b1;
               if (zero_s) begin
                  state_s = st_done;
               end else begin
                  state_s = st_run;
               end
            end else begin
               state_s = st_idle;
            end
         end
         st_run: begin
            if (cnt_r == CW'(1)) begin
               state_s = st_done;
            end else begin
               state_s = st_run;
            end
         end
         st_done: state_s = st_idle;
         default: state_s = st_idle;
      endcase
   end

   // One restoring step. The partial remainder is always below |divisor|, so the shifted value fits in WIDTH bits.
   always_comb begin
      rem_sh_s = {rem_r[WIDTH-2:0], quo_r[WIDTH-1]};
      trial_s  = {1'b0, rem_sh_s} - {1'b0, dvsr_r};
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= st_idle;
      end else begin
         state_r <= state_s;
      end
   end

   // Datapath and registered outputs. The done pulse is issued on the edge that leaves st_done.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r      <= {CW{1'b0}};
         rem_r      <= {WIDTH{1'b0}};
         quo_r      <= {WIDTH{1'b0}};
         dvsr_r     <= {WIDTH{1'b0}};
         hi_r       <= {WIDTH{1'b0}};
         lo_r       <= {WIDTH{1'b0}};
         sign_q_r   <= 1'b0;
         sign_rem_r <= 1'b0;
         dz_r       <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         div_zero_r <= 1'b0;
      end else begin
         done_r     <= 1'b0;
         div_zero_r <= 1'b0;
         case (state_r)
            st_idle: begin
               if (accept_s) begin
                  dz_r <= zero_s;
                  if (!zero_s) begin
                     quo_r      <= f_abs(bus.dividend);
                     dvsr_r     <= f_abs(bus.divisor);
                     rem_r      <= {WIDTH{1'b0}};
                     cnt_r      <= CW'(WIDTH);
                     sign_q_r   <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                     sign_rem_r <= bus.dividend[WIDTH-1];
                     busy_r     <= 1'b1;
                  end
               end
            end
            st_run: begin
               rem_r <= trial_s[WIDTH] ? rem_sh_s : trial_s[WIDTH-1:0];
               quo_r <= {quo_r[WIDTH-2:0], ~trial_s[WIDTH]};
               cnt_r <= cnt_r - CW'(1);
            end
            st_done: begin
               done_r     <= 1'b1;
               div_zero_r <= dz_r;
               busy_r     <= 1'b0;
               if (!dz_r) begin
                  lo_r <= sign_q_r   ? f_neg(quo_r) : quo_r;
                  hi_r <= sign_rem_r ? f_neg(rem_r) : rem_r;
               end
            end
            default: begin
               busy_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.hi       = hi_r;
   assign bus.lo       = lo_r;
   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
   assign bus.div_zero = div_zero_r;
endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq. Directed scenarios and a randomized run are checked against
// a reference model that uses plain 64-bit signed arithmetic.
module tb_div_seq;
   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;

   div_seq_if #(.WIDTH(32)) bus ();

   div_seq #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: C-style truncating division. The remainder takes the sign of the dividend.
   function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic [31:0] r);
      longint     la;
      longint     lb;
      logic [63:0] qq;
      logic [63:0] rr;
      la = longint'($signed(a));
      lb = longint'($signed(b));
      qq = la / lb;
      rr = la % lb;
      q  = qq[31:0];
      r  = rr[31:0];
   endfunction

   // Issues one request and returns what was observed. k counts edges after the start edge until done.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int inj_k,
                         output int k, output logic [31:0] h, output logic [31:0] l,
                         output logic dz, output int busy_cnt, output int done_cnt);
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      @(posedge clk); #1;
      bus.start    = 1'b0;
      bus.dividend = $urandom;
      bus.divisor  = $urandom;
      k        = 0;
      busy_cnt = int'(bus.busy);
      done_cnt = int'(bus.done);
      while (!bus.done && k < 100) begin
         if (k == inj_k) begin
            bus.start    = 1'b1;
            bus.dividend = 32'd50;
            bus.divisor  = 32'd5;
         end else begin
            bus.start = 1'b0;
         end
         @(posedge clk); #1;
         k++;
         busy_cnt += int'(bus.busy);
         if (bus.done) done_cnt++;
      end
      bus.start = 1'b0;
      h  = bus.hi;
      l  = bus.lo;
      dz = bus.div_zero;
      repeat (4) begin
         @(posedge clk); #1;
         if (bus.done) done_cnt++;
      end
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.dividend = 32'd0;
      bus.divisor  = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({bus.hi, bus.lo, bus.busy, bus.done, bus.div_zero} !== {64'd0, 3'b000}) begin
         n_err++;
         $display("FAIL reset: hi=%h lo=%h busy=%b done=%b dz=%b, required all zero",
                  bus.hi, bus.lo, bus.busy, bus.done, bus.div_zero);
      end
      reset = 1'b0;
   endtask

   task automatic test_basic();
      int k, bc, dc; logic [31:0] h, l; logic dz;
      run_op(32'd7, 32'd2, -1, k, h, l, dz, bc, dc);
      n_cmp++;
      if (k !== 33) begin n_err++; $display("FAIL basic_latency: got %0d required 33", k); end
      n_cmp++;
      if ({l, h, dz} !== {32'd3, 32'd1, 1'b0}) begin
         n_err++; $display("FAIL basic_7_2: lo=%h hi=%h dz=%b required 3 1 0", l, h, dz);
      end
      n_cmp++;
      if (bc !== 33) begin n_err++; $display("FAIL basic_busy_cycles: got %0d required 33", bc); end
      n_cmp++;
      if (dc !== 1) begin n_err++; $display("FAIL basic_done_count: got %0d required 1", dc); end
   endtask

   task automatic test_signs();
      int k, bc, dc; logic [31:0] h, l; logic dz;
      run_op(32'hFFFF_FFF9, 32'd2, -1, k, h, l, dz, bc, dc);
      n_cmp++;
      if ({l, h} !== {32'hFFFF_FFFD, 32'hFFFF_FFFF}) begin
         n_err++; $display("FAIL sign_neg7_2: lo=%h hi=%h required fffffffd ffffffff", l, h);
      end
      run_op(32'd7, 32'hFFFF_FFFE, -1, k, h, l, dz, bc, dc);
      n_cmp++;
      if ({l, h} !== {32'hFFFF_FFFD, 32'h0000_0001}) begin
         n_err++; $display("FAIL sign_7_neg2: lo=%h hi=%h required fffffffd 00000001", l, h);
      end
   endtask

   task automatic test_div_zero();
      int k, bc, dc; logic [31:0] h, l; logic dz;
      run_op(32'd100, 32'd7, -1, k, h, l, dz, bc, dc);
      n_cmp++;
      if ({l, h} !== {32'd14, 32'd2}) begin
         n_err++; $display("FAIL dz_preload: lo=%h hi=%h required e 2", l, h);
      end
      run_op(32'd5, 32'd0, -1, k, h, l, dz, bc, dc);
      n_cmp++;
      if (k !== 1) begin n_err++; $display("FAIL dz_latency: got %0d required 1", k); end
      n_cmp++;
      if ({dz, l, h} !== {1'b1, 32'd14, 32'd2}) begin
         n_err++; $display("FAIL dz_hold: dz=%b lo=%h hi=%h required 1 e 2", dz, l, h);
      end
      n_cmp++;
      if (bc !== 0) begin n_err++; $display("FAIL dz_busy: busy cycles %0d required 0", bc); end
   endtask

   task automatic test_overflow_zero();
      int k, bc, dc; logic [31:0] h, l; logic dz;
      run_op(32'h8000_0000, 32'hFFFF_FFFF, -1, k, h, l, dz, bc, dc);
      n_cmp++;
      if ({k, l, h} !== {32'd33, 32'h8000_0000, 32'd0}) begin
         n_err++; $display("FAIL overflow: k=%0d lo=%h hi=%h required 33 80000000 0", k, l, h);
      end
      run_op(32'd0, 32'd9, -1, k, h, l, dz, bc, dc);
      n_cmp++;
      if ({l, h} !== {32'd0, 32'd0}) begin
         n_err++; $display("FAIL zero_num: lo=%h hi=%h required 0 0", l, h);
      end
   endtask

   task automatic test_ignored_start();
      int k, bc, dc; logic [31:0] h, l; logic dz;
      run_op(32'd100, 32'd7, 10, k, h, l, dz, bc, dc);
      n_cmp++;
      if ({k, l, h} !== {32'd33, 32'd14, 32'd2}) begin
         n_err++; $display("FAIL ignored_start: k=%0d lo=%h hi=%h required 33 e 2", k, l, h);
      end
      n_cmp++;
      if (dc !== 1) begin n_err++; $display("FAIL ignored_done_count: got %0d required 1", dc); end
   endtask

   task automatic test_reset_abort();
      int k, bc, dc, extra; logic [31:0] h, l; logic dz;
      @(negedge clk);
      bus.start = 1'b1; bus.dividend = 32'd100; bus.divisor = 32'd7;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (11) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if ({bus.busy, bus.done, bus.hi, bus.lo} !== {2'b00, 64'd0}) begin
         n_err++; $display("FAIL reset_abort: busy=%b done=%b hi=%h lo=%h required 0 0 0 0",
                           bus.busy, bus.done, bus.hi, bus.lo);
      end
      reset = 1'b0;
      extra = 0;
      repeat (30) begin @(posedge clk); #1; if (bus.done) extra++; end
      n_cmp++;
      if (extra !== 0) begin n_err++; $display("FAIL abort_no_done: got %0d pulses required 0", extra); end
      run_op(32'd9, 32'd3, -1, k, h, l, dz, bc, dc);
      n_cmp++;
      if ({l, h} !== {32'd3, 32'd0}) begin
         n_err++; $display("FAIL after_reset: lo=%h hi=%h required 3 0", l, h);
      end
   endtask

   task automatic test_random();
      int k, bc, dc; logic [31:0] h, l, a, b, eq, er, pq, pr; logic dz;
      pq = 32'd3; pr = 32'd0;
      for (int i = 0; i < 24; i++) begin
         a = $urandom;
         b = $urandom;
         if (i % 4 == 1) b = 32'($signed($urandom_range(0, 20)) - 10);
         if (i % 6 == 2) b = 32'd0;
         if (i % 5 == 3) a = 32'($urandom_range(0, 1000));
         if (b == 32'd0) begin
            eq = pq; er = pr;
         end else begin
            model(a, b, eq, er);
         end
         run_op(a, b, -1, k, h, l, dz, bc, dc);
         n_cmp++;
         if ({l, h, dz, k} !== {eq, er, (b == 32'd0), ((b == 32'd0) ? 32'd1 : 32'd33)}) begin
            n_err++;
            $display("FAIL random_%0d: %h/%h lo=%h hi=%h dz=%b k=%0d required lo=%h hi=%h",
                     i, a, b, l, h, dz, k, eq, er);
         end
         pq = eq; pr = er;
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_basic();
      test_signs();
      test_div_zero();
      test_overflow_zero();
      test_ignored_start();
      test_reset_abort();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
